// File: rtl/alu_muldiv_mc.sv
// rtl/alu_muldiv_mc.sv - multi-cycle ALU with iterative mul/div and HI/LO
// Single-cycle ops complete in IDLE; mul/div run WIDTH CALC steps then one FIX step.
module alu_muldiv_mc #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Start,
  input  logic [3:0]         ALUOperation,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [SHAMT_W-1:0] Shamt,
  output logic [WIDTH-1:0]   ALUResult,
  output logic               Zero,
  output logic               Overflow,
  output logic               Busy,
  output logic               Done,
  output logic               DivZero,
  output logic [WIDTH-1:0]   HI,
  output logic [WIDTH-1:0]   LO
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_NOR   = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_LUI   = 4'd5;
  localparam logic [3:0] OP_SLL   = 4'd6;
  localparam logic [3:0] OP_SRL   = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_SLT   = 4'd9;
  localparam logic [3:0] OP_SLTU  = 4'd10;
  localparam logic [3:0] OP_MULT  = 4'd11;
  localparam logic [3:0] OP_MULTU = 4'd12;
  localparam logic [3:0] OP_DIV   = 4'd13;
  localparam logic [3:0] OP_DIVU  = 4'd14;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  acc_hi_q, acc_lo_q, mb_q, a_raw_q;
  logic              is_div_q, neg_q, neg_rem_q, dz_q;
  logic [WIDTH-1:0]  alu_q, hi_q, lo_q;
  logic              zero_q, ovf_q, done_q, divzero_q;

  logic [WIDTH-1:0]  sum, diff, res_d;
  logic              ovf_d;
  logic              is_md, is_div, signed_op, sa, sb;
  logic [WIDTH-1:0]  mag_a, mag_b;

  assign sum  = A + B;
  assign diff = A - B;

  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    case (ALUOperation)
      OP_AND:  res_d = A & B;
      OP_OR:   res_d = A | B;
      OP_NOR:  res_d = ~(A | B);
      OP_ADD: begin
        res_d = sum;
        ovf_d = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        res_d = diff;
        ovf_d = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_LUI:  res_d = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLL:  res_d = A << Shamt;
      OP_SRL:  res_d = A >> Shamt;
      OP_SRA:  res_d = $signed(A) >>> Shamt;
      OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, A < B};
      default: res_d = '0;
    endcase
  end

  assign is_md     = (ALUOperation >= OP_MULT) && (ALUOperation <= OP_DIVU);
  assign is_div    = (ALUOperation == OP_DIV) || (ALUOperation == OP_DIVU);
  assign signed_op = (ALUOperation == OP_MULT) || (ALUOperation == OP_DIV);
  assign sa        = signed_op & A[WIDTH-1];
  assign sb        = signed_op & B[WIDTH-1];
  assign mag_a     = sa ? -A : A;
  assign mag_b     = sb ? -B : B;

  // Multiply: acc_lo holds the multiplier and shifts out as product bits shift in.
  logic [WIDTH:0]   madd;
  assign madd = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mb_q} : {(WIDTH+1){1'b0}});

  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  logic [WIDTH:0]   trial, dsub;
  assign trial = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign dsub  = trial - {1'b0, mb_q};

  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  always_comb begin
    step_hi = '0;
    step_lo = '0;
    if (is_div_q) begin
      step_hi = dsub[WIDTH] ? trial[WIDTH-1:0] : dsub[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], ~dsub[WIDTH]};
    end else begin
      step_hi = madd[WIDTH:1];
      step_lo = {madd[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_s = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    fix_hi = prod_s[2*WIDTH-1:WIDTH];
    fix_lo = prod_s[WIDTH-1:0];
    if (is_div_q) begin
      if (dz_q) begin
        fix_hi = a_raw_q;
        fix_lo = '1;
      end else begin
        fix_hi = neg_rem_q ? -acc_hi_q : acc_hi_q;
        fix_lo = neg_q ? -acc_lo_q : acc_lo_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      mb_q      <= '0;
      a_raw_q   <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      alu_q     <= '0;
      zero_q    <= 1'b1;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            divzero_q <= 1'b0;
            if (is_md) begin
              state_q   <= S_CALC;
              cnt_q     <= '0;
              acc_hi_q  <= '0;
              acc_lo_q  <= is_div ? mag_a : mag_b;
              mb_q      <= is_div ? mag_b : mag_a;
              a_raw_q   <= A;
              is_div_q  <= is_div;
              neg_q     <= sa ^ sb;
              neg_rem_q <= sa;
              dz_q      <= is_div && (B == '0);
            end else begin
              alu_q  <= res_d;
              zero_q <= (res_d == '0);
              ovf_q  <= ovf_d;
              done_q <= 1'b1;
            end
          end
        end
        S_CALC: begin
          acc_hi_q <= step_hi;
          acc_lo_q <= step_lo;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q      <= fix_hi;
          lo_q      <= fix_lo;
          divzero_q <= dz_q;
          done_q    <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ALUResult = alu_q;
  assign Zero      = zero_q;
  assign Overflow  = ovf_q;
  assign Busy      = (state_q != S_IDLE);
  assign Done      = done_q;
  assign DivZero   = divzero_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_alu_muldiv_mc.sv
// tb/tb_alu_muldiv_mc.sv - table-driven bench for alu_muldiv_mc
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_alu_muldiv_mc;

  logic        clk = 1'b0;
  logic        reset, Start;
  logic [3:0]  ALUOperation;
  logic [31:0] A, B;
  logic [4:0]  Shamt;
  logic [31:0] ALUResult, HI, LO;
  logic        Zero, Overflow, Busy, Done, DivZero;

  always #5 clk = ~clk;

  alu_muldiv_mc #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .Start(Start), .ALUOperation(ALUOperation),
    .A(A), .B(B), .Shamt(Shamt), .ALUResult(ALUResult), .Zero(Zero),
    .Overflow(Overflow), .Busy(Busy), .Done(Done), .DivZero(DivZero),
    .HI(HI), .LO(LO)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic        md;
    logic [31:0] res;
    logic        z, ov;
    logic [31:0] hi, lo;
    logic        dz;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] m_res, m_hi, m_lo;
  logic        m_z, m_ov;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] sh, input logic md, input logic [31:0] res,
                              input logic z, input logic ov, input logic [31:0] hi,
                              input logic [31:0] lo, input logic dz);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.sh = sh; v.md = md; v.res = res;
    v.z = z; v.ov = ov; v.hi = hi; v.lo = lo; v.dz = dz;
    return v;
  endfunction

  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh);
    ALUOperation = op; A = a; B = b; Shamt = sh; Start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic wait_md(output int cyc, output int dones);
    cyc = 0;
    dones = 0;
    while (Busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (Done) dones++;
      @(negedge clk);
    end
  endtask

  vec_t vt [22];
  int   cyc, dones;

  initial begin
    vt[0]  = mk(4'd3,  32'h7FFFFFFF, 32'h1,        5'd0,  0, 32'h80000000, 0, 1, 0, 0, 0);
    vt[1]  = mk(4'd4,  32'd5,        32'd5,        5'd0,  0, 32'h0,        1, 0, 0, 0, 0);
    vt[2]  = mk(4'd8,  32'h80000000, 32'h0,        5'd4,  0, 32'hF8000000, 0, 0, 0, 0, 0);
    vt[3]  = mk(4'd7,  32'h80000000, 32'h0,        5'd4,  0, 32'h08000000, 0, 0, 0, 0, 0);
    vt[4]  = mk(4'd9,  32'hFFFFFFFF, 32'h1,        5'd0,  0, 32'h1,        0, 0, 0, 0, 0);
    vt[5]  = mk(4'd10, 32'hFFFFFFFF, 32'h1,        5'd0,  0, 32'h0,        1, 0, 0, 0, 0);
    vt[6]  = mk(4'd5,  32'h0,        32'h1234,     5'd0,  0, 32'h12340000, 0, 0, 0, 0, 0);
    vt[7]  = mk(4'd0,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  0, 32'hF000F000, 0, 0, 0, 0, 0);
    vt[8]  = mk(4'd1,  32'h0F0F0000, 32'h000000F0, 5'd0,  0, 32'h0F0F00F0, 0, 0, 0, 0, 0);
    vt[9]  = mk(4'd2,  32'h0,        32'h0,        5'd0,  0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
    vt[10] = mk(4'd6,  32'h1,        32'h0,        5'd31, 0, 32'h80000000, 0, 0, 0, 0, 0);
    vt[11] = mk(4'd15, 32'h5,        32'h3,        5'd0,  0, 32'h0,        1, 0, 0, 0, 0);
    vt[12] = mk(4'd3,  32'hFFFFFFFF, 32'h1,        5'd0,  0, 32'h0,        1, 0, 0, 0, 0);
    vt[13] = mk(4'd4,  32'h80000000, 32'h1,        5'd0,  0, 32'h7FFFFFFF, 0, 1, 0, 0, 0);
    vt[14] = mk(4'd11, 32'hFFFFFFFD, 32'd7,        5'd0,  1, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    vt[15] = mk(4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  1, 0, 0, 0, 32'hFFFFFFFE, 32'h00000001, 0);
    vt[16] = mk(4'd14, 32'd100,      32'd7,        5'd0,  1, 0, 0, 0, 32'd2,        32'd14,       0);
    vt[17] = mk(4'd13, 32'hFFFFFFF9, 32'd2,        5'd0,  1, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    vt[18] = mk(4'd13, 32'h80000000, 32'hFFFFFFFF, 5'd0,  1, 0, 0, 0, 32'h0,        32'h80000000, 0);
    vt[19] = mk(4'd13, 32'd7,        32'hFFFFFFFE, 5'd0,  1, 0, 0, 0, 32'h1,        32'hFFFFFFFD, 0);
    vt[20] = mk(4'd14, 32'd9,        32'd0,        5'd0,  1, 0, 0, 0, 32'd9,        32'hFFFFFFFF, 1);
    vt[21] = mk(4'd3,  32'd2,        32'd3,        5'd0,  0, 32'd5,        0, 0, 0, 0, 0);

    reset = 1'b1; Start = 1'b0; ALUOperation = '0; A = '0; B = '0; Shamt = '0;
    m_res = '0; m_z = 1'b1; m_ov = 1'b0; m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset ALUResult", ALUResult, 32'h0);
    chk("reset Zero", Zero, 1);
    chk("reset Overflow", Overflow, 0);
    chk("reset Busy", Busy, 0);
    chk("reset Done", Done, 0);
    chk("reset DivZero", DivZero, 0);
    chk("reset HI", HI, 0);
    chk("reset LO", LO, 0);

    for (int i = 0; i < 22; i++) begin
      start_op(vt[i].op, vt[i].a, vt[i].b, vt[i].sh);
      n_vec++;
      if (!vt[i].md) begin
        m_res = vt[i].res; m_z = vt[i].z; m_ov = vt[i].ov;
        chk($sformatf("v%0d Done", i), Done, 1);
        chk($sformatf("v%0d Busy", i), Busy, 0);
      end else begin
        m_hi = vt[i].hi; m_lo = vt[i].lo;
        wait_md(cyc, dones);
        chk($sformatf("v%0d busy cycles", i), cyc, 33);
        chk($sformatf("v%0d early Done", i), dones, 0);
        chk($sformatf("v%0d Done", i), Done, 1);
      end
      chk($sformatf("v%0d ALUResult", i), ALUResult, m_res);
      chk($sformatf("v%0d Zero", i), Zero, m_z);
      chk($sformatf("v%0d Overflow", i), Overflow, m_ov);
      chk($sformatf("v%0d HI", i), HI, m_hi);
      chk($sformatf("v%0d LO", i), LO, m_lo);
      chk($sformatf("v%0d DivZero", i), DivZero, vt[i].dz);
      @(negedge clk);
      chk($sformatf("v%0d Done pulse", i), Done, 0);
    end

    // Start mid-MULT is ignored; a Start in the Done cycle is accepted.
    start_op(4'd11, 32'd5, 32'd6, 5'd0);
    n_vec++;
    repeat (5) @(negedge clk);
    ALUOperation = 4'd3; A = 32'd1; B = 32'd1; Start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    chk("midmul ALUResult", ALUResult, m_res);
    chk("midmul Busy", Busy, 1);
    chk("midmul Done", Done, 0);
    wait_md(cyc, dones);
    chk("midmul remaining cycles", cyc, 27);
    chk("midmul Done", Done, 1);
    chk("midmul HI", HI, 32'h0);
    chk("midmul LO", LO, 32'd30);
    chk("midmul ALUResult after", ALUResult, m_res);
    start_op(4'd3, 32'd1, 32'd1, 5'd0);
    n_vec++;
    chk("done-cycle start ALUResult", ALUResult, 32'd2);
    chk("done-cycle start Done", Done, 1);
    chk("done-cycle start Busy", Busy, 0);

    // Back-to-back single-cycle ops.
    ALUOperation = 4'd3; A = 32'd1; B = 32'd2; Start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    chk("b2b first", ALUResult, 32'd3);
    chk("b2b first Done", Done, 1);
    ALUOperation = 4'd4; A = 32'd9; B = 32'd4;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    Start = 1'b0;
    chk("b2b second", ALUResult, 32'd5);
    chk("b2b second Done", Done, 1);
    @(negedge clk);
    chk("b2b idle Done", Done, 0);
    chk("b2b hold", ALUResult, 32'd5);

    // Reset in CALC cycle 10 aborts the multiply.
    start_op(4'd11, 32'd3, 32'd4, 5'd0);
    n_vec++;
    repeat (9) @(negedge clk);
    chk("pre-reset Busy", Busy, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort Busy", Busy, 0);
    chk("abort Done", Done, 0);
    chk("abort HI", HI, 0);
    chk("abort LO", LO, 0);
    chk("abort ALUResult", ALUResult, 0);
    chk("abort Zero", Zero, 1);
    @(negedge clk);
    chk("abort Done later", Done, 0);
    start_op(4'd11, 32'd12, 32'hFFFFFFFE, 5'd0);
    n_vec++;
    wait_md(cyc, dones);
    chk("post-reset busy cycles", cyc, 33);
    chk("post-reset Done", Done, 1);
    chk("post-reset HI", HI, 32'hFFFFFFFF);
    chk("post-reset LO", LO, 32'hFFFFFFE8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
